// File: rtl/rom_arbiter.sv
// Two-master arbiter in front of the single-port synchronous BASIC ROM.
// Grants are combinational; read data comes back from the ROM one cycle after the grant.
module rom_arbiter #(
  parameter int ROUND_ROBIN  = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [11:0] cpu_addr,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  input  logic        aux_req,
  input  logic [11:0] aux_addr,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [7:0]  aux_rdata,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_dout
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       last_q, last_d;
  logic       cpu_rvalid_q, aux_rvalid_q;
  logic       cpu_win, aux_win;

  // Winner selection: a lone requester always wins; contention resolved by mode
  always_comb begin
    cpu_win = 1'b0;
    aux_win = 1'b0;
    if (!rst) begin
      if (cpu_req && !aux_req) begin
        cpu_win = 1'b1;
      end else if (aux_req && !cpu_req) begin
        aux_win = 1'b1;
      end else if (cpu_req && aux_req) begin
        if (ROUND_ROBIN != 0) begin
          if (last_q) cpu_win = 1'b1;
          else        aux_win = 1'b1;
        end else if (wait_cnt_q == LIMIT) begin
          aux_win = 1'b1;
        end else begin
          cpu_win = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    last_d     = last_q;
    if (ROUND_ROBIN != 0) begin
      wait_cnt_d = 4'd0;
      if (cpu_win)      last_d = 1'b0;
      else if (aux_win) last_d = 1'b1;
    end else if (!aux_req || aux_win) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != LIMIT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q   <= 4'd0;
      last_q       <= 1'b1;
      cpu_rvalid_q <= 1'b0;
      aux_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      last_q       <= last_d;
      cpu_rvalid_q <= cpu_win;
      aux_rvalid_q <= aux_win;
    end
  end

  // Strobes are masked during reset so a read in flight when rst rises is discarded
  always_comb begin
    cpu_gnt    = cpu_win;
    aux_gnt    = aux_win;
    rom_addr   = aux_win ? aux_addr : cpu_addr;
    cpu_rvalid = cpu_rvalid_q & ~rst;
    aux_rvalid = aux_rvalid_q & ~rst;
    cpu_rdata  = rom_dout;
    aux_rdata  = rom_dout;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a priority-mode and a round-robin-mode instance run side by side,
// each with its own ROM model, request generator, reference arbiter and read-data scoreboard.
module tb_rom_arbiter;

  localparam int LIMIT = 4;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req      [2][2];
  logic [11:0] addr     [2][2];
  logic        gnt      [2][2];
  logic        rv       [2][2];
  logic [7:0]  rd       [2][2];
  logic [11:0] rom_addr [2];
  logic [7:0]  rom_dout [2];
  logic [7:0]  mem      [4096];

  exp_t        sb [2][2][$];
  bit          pend     [2][2];
  logic [11:0] paddr    [2][2];
  logic [11:0] seq_addr [2][2];
  int          wait_m   [2];
  bit          last_m   [2];
  int          win      [2];
  logic [9:0]  pat      [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_arbiter #(.ROUND_ROBIN(0), .STARVE_LIMIT(LIMIT)) u_pri (
    .clk(clk), .rst(rst),
    .cpu_req(req[0][0]), .cpu_addr(addr[0][0]), .cpu_gnt(gnt[0][0]),
    .cpu_rvalid(rv[0][0]), .cpu_rdata(rd[0][0]),
    .aux_req(req[0][1]), .aux_addr(addr[0][1]), .aux_gnt(gnt[0][1]),
    .aux_rvalid(rv[0][1]), .aux_rdata(rd[0][1]),
    .rom_addr(rom_addr[0]), .rom_dout(rom_dout[0])
  );

  rom_arbiter #(.ROUND_ROBIN(1), .STARVE_LIMIT(LIMIT)) u_rr (
    .clk(clk), .rst(rst),
    .cpu_req(req[1][0]), .cpu_addr(addr[1][0]), .cpu_gnt(gnt[1][0]),
    .cpu_rvalid(rv[1][0]), .cpu_rdata(rd[1][0]),
    .aux_req(req[1][1]), .aux_addr(addr[1][1]), .aux_gnt(gnt[1][1]),
    .aux_rvalid(rv[1][1]), .aux_rdata(rd[1][1]),
    .rom_addr(rom_addr[1]), .rom_dout(rom_dout[1])
  );

  // Synchronous-read ROM wrapper models
  always @(posedge clk) rom_dout[0] <= mem[rom_addr[0]];
  always @(posedge clk) rom_dout[1] <= mem[rom_addr[1]];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Reference arbitration: m=0 is CPU-priority with starvation guard, m=1 is round-robin
  function automatic int ref_winner(input int m, input bit r, input bit rc, input bit ra);
    if (r)          return -1;
    if (rc && !ra)  return 0;
    if (ra && !rc)  return 1;
    if (!rc)        return -1;
    if (m == 1)     return last_m[1] ? 0 : 1;
    return (wait_m[0] == LIMIT) ? 1 : 0;
  endfunction

  task automatic ref_update(input int m, input bit r, input bit ra, input int w);
    if (r) begin
      wait_m[m] = 0;
      last_m[m] = 1'b1;
    end else if (m == 1) begin
      if (w == 0) last_m[1] = 1'b0;
      if (w == 1) last_m[1] = 1'b1;
    end else if (!ra || w == 1) begin
      wait_m[0] = 0;
    end else if (wait_m[0] < LIMIT) begin
      wait_m[0]++;
    end
  endtask

  // One clock of stimulus: idle ports listed in want[] issue a new read, pending ones hold
  task automatic step(input bit r, input bit want_c, input bit want_a, input bit seq);
    bit want [2];
    want[0] = want_c;
    want[1] = want_a;
    @(negedge clk);
    rst = r;
    for (int m = 0; m < 2; m++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[m][p] && want[p]) begin
          pend[m][p] = 1'b1;
          if (seq) begin
            paddr[m][p]    = seq_addr[m][p];
            seq_addr[m][p] = seq_addr[m][p] + 12'd1;
          end else begin
            paddr[m][p] = 12'($urandom);
          end
        end
        req[m][p]  = pend[m][p];
        addr[m][p] = pend[m][p] ? paddr[m][p] : 12'($urandom);
        if (r) sb[m][p].delete();
      end
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      win[m] = ref_winner(m, r, req[m][0], req[m][1]);
      for (int p = 0; p < 2; p++)
        check($sformatf("m%0d_gnt%0d", m, p), 32'(gnt[m][p]), 32'(win[m] == p));
      if (win[m] >= 0) begin
        sb[m][win[m]].push_back('{d: mem[paddr[m][win[m]]], due: cyc + 1});
        pend[m][win[m]] = 1'b0;
      end
      ref_update(m, r, req[m][1], win[m]);
    end
  endtask

  // Read-return monitor
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int m = 0; m < 2; m++) begin
        for (int p = 0; p < 2; p++) begin
          bit   exp_v;
          exp_t e;
          exp_v = (sb[m][p].size() > 0) && (sb[m][p][0].due == cyc);
          check($sformatf("m%0d_rvalid%0d", m, p), 32'(rv[m][p]), 32'(exp_v));
          if (exp_v) begin
            e = sb[m][p].pop_front();
            if (rv[m][p])
              check($sformatf("m%0d_rdata%0d", m, p), 32'(rd[m][p]), 32'(e.d));
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h000] = 8'h4C;
    mem[12'h123] = 8'hA5;
    for (int m = 0; m < 2; m++) begin
      wait_m[m] = 0;
      last_m[m] = 1'b1;
      pat[m]    = '0;
      for (int p = 0; p < 2; p++) begin
        pend[m][p] = 1'b0;
        req[m][p]  = 1'b0;
        addr[m][p] = '0;
      end
    end

    // Reset held with both masters requesting
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);

    // Continuous contention right after reset
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      for (int m = 0; m < 2; m++) pat[m] = {pat[m][8:0], 1'(win[m] == 1)};
    end
    check("pri_pattern", 32'(pat[0]), 32'(10'b0000100001));
    check("rr_pattern",  32'(pat[1]), 32'(10'b0101010101));
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back CPU reads 0x000..0x003, aux idle
    for (int m = 0; m < 2; m++) seq_addr[m][0] = 12'h000;
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional reset pulses
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 9) < 6), 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset right after a CPU grant at 0x123, then reissue
    for (int m = 0; m < 2; m++) seq_addr[m][0] = 12'h123;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) seq_addr[m][0] = 12'h123;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    for (int m = 0; m < 2; m++)
      for (int p = 0; p < 2; p++)
        check($sformatf("m%0d_drain%0d", m, p), 32'(sb[m][p].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
